matrix_mult_seq: RTL
====================

Name: matrix_mult_seq

Overview:
- Parametrised sequential NxN matrix multiplier. It is the successor to the team's fixed 2x2 combinational matrix multiplier.
- Operands arrive element by element on a valid/ready input stream. A single multiply-accumulate unit computes C = A x B. Results leave on a valid/ready output stream.
- Intended as the reusable matrix engine behind stream sources and sinks in larger datapaths.

Parameters:
- N, default 2: matrix dimension, legal range 1..8.
- DW, default 8: element width of A and B.
- SIGNED, default 0: 0 treats operands as unsigned; 1 treats them as two's complement.
- AW, derived, 2*DW + $clog2(N) (N=1 gives 2*DW): result element width. Localparam, not overridable.

Ports:
- clk  in  1  Clock. All logic is rising-edge.
- rst  in  1  Reset, synchronous, active-high.
- in_valid  in  1  in_data holds a valid element.
- in_ready  out  1  Block accepts an element this cycle.
- in_data  in  DW  Operand element.
- out_valid  out  1  out_data holds a valid result element.
- out_ready  in  1  Sink accepts the result element.
- out_data  out  AW  Result element C[i][j].
- out_last  out  1  Asserted with C[N-1][N-1].
- busy  out  1  High in COMPUTE and OUT.

Behaviour:
- Reset (rst sampled high at a clk edge):
  - State goes to LOAD; all counters and the accumulator clear.
  - in_ready=1, out_valid=0, out_last=0, busy=0, out_data=0.
  - Operand and result buffer contents are don't-care.
  - Reset has priority over every other event and aborts any state, including mid-LOAD, mid-COMPUTE and mid-OUT. Partial data is discarded.
- State machine: LOAD -> COMPUTE -> OUT -> LOAD.
- LOAD:
  - in_ready=1; busy=0.
  - Each cycle with in_valid&in_ready stores one element.
  - Order: the first N*N beats are A, row-major (A[0][0], A[0][1], ...). The next N*N beats are B, row-major.
  - Cycles with in_valid=0 leave the beat counter unchanged.
  - On the cycle accepting beat 2*N*N-1 (call it cycle T), the next state is COMPUTE.
- COMPUTE:
  - in_ready=0; in_valid is ignored; busy=1.
  - Loop counters i (row), j (column), k (inner); k is innermost, then j, then i.
  - Each cycle: acc <= acc + A[i][k]*B[k][j].
  - When k==N-1: C[i][j] <= acc + product, acc <= 0, k wraps to 0, and j (then i) advances.
  - Exactly N^3 cycles. After storing C[N-1][N-1], the next state is OUT.
  - The product is DW x DW -> 2*DW bits, signed or unsigned per SIGNED, then extended to AW (sign-extended when SIGNED=1).
  - AW guarantees no overflow for any operand values, so no saturation or wrap is needed.
- OUT:
  - out_valid=1; out_data presents C row-major, starting at C[0][0].
  - An element advances only on out_valid&out_ready.
  - out_data and out_last hold stable while out_ready=0.
  - out_last=1 only while presenting C[N-1][N-1].
  - Handshake on the last element: the next cycle is LOAD with out_valid=0 and in_ready=1.
- Latency:
  - First out_valid is at cycle T+1+N^3 (registered; no combinational path from in_* to out_*).
  - Minimum turnaround per matrix is 2*N^2 + N^3 + N^2 cycles.
- Boundary rules:
  - N=1: single MAC; COMPUTE lasts 1 cycle.
  - The in_valid/in_ready and out_valid/out_ready handshakes are never active in the same cycle.

Test Plan:
- N=2, DW=8, SIGNED=0. Stream A=1,2,3,4 then B=5,6,7,8 with in_valid held high; out_ready=1.
  - Required: out_data 19,22,43,50 on 4 consecutive cycles, out_last on 50.
  - Required: first out_valid exactly 9 cycles after the last input beat (N^3+1).
- N=2, all elements 255.
  - Required: every result = 130050 (17-bit AW), no truncation.
- SIGNED=1, N=2. A=-1,2,3,-4 (0xFF,0x02,0x03,0xFC); B=identity (1,0,0,1).
  - Required: out_data -1,2,3,-4 sign-extended to 17 bits (0x1FFFF, 2, 3, 0x1FFFC).
- Backpressure and bubbles. Random in_valid gaps during LOAD; out_ready toggled 0/1 during OUT.
  - Required: identical results; out_data stable while out_ready=0.
  - Required: in_ready=0 throughout COMPUTE/OUT, and in_valid pulses there have no effect.
- Assert rst for 1 cycle mid-COMPUTE.
  - Required: next cycle in_ready=1, out_valid=0, busy=0.
  - Required: a fresh load of the first test's operands then yields 19,22,43,50.
- Two matrices back-to-back, N=3. A=1..9, B=identity, then A=1..9, B=all-ones.
  - Required: first output 1..9.
  - Required: second output 6,6,6,15,15,15,24,24,24.

Source files
------------

// File: rtl/matrix_mult_seq.sv
// ============================================================================
// matrix_mult_seq
//
// Sequential NxN matrix multiplier, C = A x B, built around a single
// multiply-accumulate unit.
//
//   LOAD    : accept 2*N*N operand elements on the input stream,
//             A row-major first, then B row-major.
//   COMPUTE : N^3 MAC cycles, k innermost, then j, then i.
//   OUT     : present C row-major on the output stream, out_last on C[N-1][N-1].
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset, aborts any state
//   in_valid   in_data holds a valid element
//   in_ready   block accepts an element this cycle (LOAD only)
//   in_data    operand element, DW bits
//   out_valid  out_data holds a valid result element (OUT only)
//   out_ready  sink accepts the result element
//   out_data   result element C[i][j], AW bits
//   out_last   high while presenting C[N-1][N-1]
//   busy       high in COMPUTE and OUT
// ============================================================================
module matrix_mult_seq #(
    parameter int N      = 2,
    parameter int DW     = 8,
    parameter int SIGNED = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [DW-1:0]                 in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*DW+$clog2(N)-1:0]     out_data,
    output logic                          out_last,
    output logic                          busy
);

    // Result width: a sum of N full-width products never overflows.
    localparam int AW = 2*DW + $clog2(N);
    localparam int NN = N*N;
    localparam int IW = (N  > 1) ? $clog2(N)  : 1;   // loop index width
    localparam int MW = (NN > 1) ? $clog2(NN) : 1;   // buffer address width
    localparam int CW = $clog2(2*NN);                // input beat counter width

    typedef enum logic [1:0] {
        LOAD,
        COMPUTE,
        OUT
    } state_t;

    state_t           state;
    state_t           state_next;

    logic [CW-1:0]    beat;
    logic [IW-1:0]    ci;
    logic [IW-1:0]    cj;
    logic [IW-1:0]    ck;
    logic [MW-1:0]    oidx;
    logic [AW-1:0]    acc;

    logic [DW-1:0]    a_mem [NN];
    logic [DW-1:0]    b_mem [NN];
    logic [AW-1:0]    c_mem [NN];

    logic             accept;
    logic             beat_last;
    logic             k_last;
    logic             j_last;
    logic             i_last;
    logic             oidx_last;
    logic             out_fire;

    logic [MW-1:0]    a_addr;
    logic [MW-1:0]    b_addr;
    logic [MW-1:0]    c_addr;
    logic [DW-1:0]    op_a;
    logic [DW-1:0]    op_b;
    logic [AW-1:0]    prod_ext;
    logic [AW-1:0]    sum;

    // ------------------------------------------------------------------
    // Status decodes
    // ------------------------------------------------------------------
    assign accept    = in_valid && (state == LOAD);
    assign beat_last = (beat == CW'(2*NN - 1));
    assign k_last    = (ck == IW'(N - 1));
    assign j_last    = (cj == IW'(N - 1));
    assign i_last    = (ci == IW'(N - 1));
    assign oidx_last = (oidx == MW'(NN - 1));
    assign out_fire  = out_ready && (state == OUT);

    // ------------------------------------------------------------------
    // MAC datapath
    // ------------------------------------------------------------------
    assign a_addr = MW'(ci*N + ck);
    assign b_addr = MW'(ck*N + cj);
    assign c_addr = MW'(ci*N + cj);
    assign op_a   = a_mem[a_addr];
    assign op_b   = b_mem[b_addr];

    generate
        if (SIGNED != 0) begin : g_signed
            logic signed [DW-1:0]   sa;
            logic signed [DW-1:0]   sb;
            logic signed [2*DW-1:0] prod;
            assign sa       = op_a;
            assign sb       = op_b;
            assign prod     = (2*DW)'(sa) * (2*DW)'(sb);
            // Signed size cast sign-extends the product into the result width.
            assign prod_ext = AW'(prod);
        end else begin : g_unsigned
            logic [2*DW-1:0] prod;
            assign prod     = (2*DW)'(op_a) * (2*DW)'(op_b);
            assign prod_ext = AW'(prod);
        end
    endgenerate

    assign sum = acc + prod_ext;

    // ------------------------------------------------------------------
    // State register, counters and accumulator
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LOAD;
            beat  <= '0;
            ci    <= '0;
            cj    <= '0;
            ck    <= '0;
            oidx  <= '0;
            acc   <= '0;
        end else begin
            state <= state_next;
            case (state)
                LOAD: begin
                    if (accept) begin
                        beat <= beat_last ? '0 : beat + CW'(1);
                    end
                end
                COMPUTE: begin
                    if (k_last) begin
                        // Dot product complete: clear for the next element.
                        acc <= '0;
                        ck  <= '0;
                        if (j_last) begin
                            cj <= '0;
                            ci <= i_last ? '0 : ci + IW'(1);
                        end else begin
                            cj <= cj + IW'(1);
                        end
                    end else begin
                        acc <= sum;
                        ck  <= ck + IW'(1);
                    end
                end
                OUT: begin
                    if (out_fire) begin
                        oidx <= oidx_last ? '0 : oidx + MW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Operand and result buffers
    // ------------------------------------------------------------------
    // NOTE: buffers carry no reset; their contents are always overwritten
    // before being read, and leaving them unreset lets them map to RAM.
    always_ff @(posedge clk) begin
        if (accept) begin
            if (beat < CW'(NN)) begin
                a_mem[MW'(beat)] <= in_data;
            end else begin
                b_mem[MW'(beat - CW'(NN))] <= in_data;
            end
        end
        if (state == COMPUTE && k_last) begin
            c_mem[c_addr] <= sum;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    // NOTE: every output gets a default before the case so no path
    // through the block leaves a signal unassigned (no inferred latch).
    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        out_last   = 1'b0;
        out_data   = '0;
        busy       = 1'b0;
        case (state)
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && beat_last) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                busy = 1'b1;
                if (k_last && j_last && i_last) begin
                    state_next = OUT;
                end
            end
            OUT: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                out_data  = c_mem[oidx];
                out_last  = oidx_last;
                if (out_ready && oidx_last) begin
                    state_next = LOAD;
                end
            end
            default: state_next = LOAD;
        endcase
    end

endmodule
